// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_pkg: shared encodings for the shift_32 link (tx and rx ends)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package shift_pkg;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  // Next value of a 194-style 32-bit universal shift register.
  function automatic logic [31:0] shift194_next(input logic [1:0] mode, input logic [31:0] q,
                                                input logic dsr, input logic dsl,
                                                input logic [31:0] d);
    logic [31:0] r;
    case (mode)
      SHR:     r = {dsr, q[31:1]};
      SHL:     r = {q[30:0], dsl};
      LOAD:    r = d;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_hold_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_hold_reg: one-word output buffer with valid/ready and overrun     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rx_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] word_i,
  input  logic             push_i,
  input  logic             ready_i,
  input  logic             err_clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] q_q;
  logic             valid_q;
  logic             overrun_q;
  logic             free;

  // A pop in the same cycle frees the slot for the incoming word.
  assign free = !valid_q || ready_i;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      q_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (push_i && free) begin
        q_q     <= word_i;
        valid_q <= 1'b1;
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end

      if (push_i && !free) begin
        overrun_q <= 1'b1;
      end else if (err_clr_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign q_o       = q_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: rtl/shift_rx_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_rx_32: serial-to-parallel receiver with holding register       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_rx_32
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             CR,
  input  logic             sdata,
  input  logic             sen,
  input  logic             sof,
  input  logic             dir,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] Q,
  output logic             out_valid,
  output logic             busy,
  output logic [CNTW-1:0]  bit_cnt,
  output logic             overrun,
  output logic             frame_err
);

  rx_state_e        state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_base;
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;
  logic             dir_q;
  logic             dir_eff;
  logic             busy_q;
  logic             frame_err_q;
  logic             accept;
  logic             complete;

  always_comb begin
    accept   = sen && (sof || (state_q == RECV));
    complete = sen && !sof && (state_q == RECV) && (cnt_q == CNTW'(WIDTH - 1));
    dir_eff  = sof ? dir : dir_q;
    // A new sof starts from a clean register so no stale bits survive.
    sr_base  = sof ? '0 : sr_q;
    sr_d     = (dir_eff == DIR_MSB_FIRST) ? {sr_base[WIDTH-2:0], sdata}
                                          : {sdata, sr_base[WIDTH-1:1]};
    cnt_d    = sof ? CNTW'(1) : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!CR) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      dir_q       <= DIR_LSB_FIRST;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= sen && sof && (state_q == RECV);
      if (accept) begin
        dir_q <= dir_eff;
        if (complete) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          sr_q    <= '0;
          cnt_q   <= '0;
        end else begin
          state_q <= RECV;
          busy_q  <= 1'b1;
          sr_q    <= sr_d;
          cnt_q   <= cnt_d;
        end
      end
    end
  end

  rx_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_ni    (CR),
    .word_i    (sr_d),
    .push_i    (complete),
    .ready_i   (out_ready),
    .err_clr_i (err_clr),
    .q_o       (Q),
    .valid_o   (out_valid),
    .overrun_o (overrun)
  );

  assign busy      = busy_q;
  assign bit_cnt   = cnt_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire
